// File: rtl/uart_rx.sv
`timescale 1ns / 1ps
// uart_rx: oversampled serial receiver (start, DATA_BITS data, stop) with a one-entry
// valid/ready holding register and single-cycle frame_err / overrun / parity_err pulses.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sample_tick,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned     TickW    = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] BitLast  = TickW'(OVERSAMPLE - 1);
  localparam logic [2:0]       LastBit  = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e           state_q, state_d;
  logic [TickW-1:0] tickcnt_q, tickcnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             done_q, done_d;       // stop bit was sampled last cycle
  logic             stop_ok_q, stop_ok_d;
  logic             rxd_meta, rxd_s, rxd_prev;
  logic [7:0]       data_q;
  logic             valid_q, frame_err_q, overrun_q;
  logic             deliver;

  // Two-flop synchronizer plus the per-tick previous sample used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      if (sample_tick) rxd_prev <= rxd_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
`endif

  // Receive FSM state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tickcnt_q <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      stop_ok_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tickcnt_q <= tickcnt_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      stop_ok_q <= stop_ok_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state logic; everything advances only on enabled sample ticks.
  always_comb begin
    state_d   = state_q;
    tickcnt_d = tickcnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    stop_ok_d = stop_ok_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (!enable) begin
      state_d   = StIdle;
      tickcnt_d = '0;
      bitcnt_d  = '0;
      shift_d   = '0;
    end else if (sample_tick) begin
      unique case (state_q)
        StIdle: begin
          // Only a 1->0 transition starts a frame, so a held-low break cannot retrigger.
          if (rxd_prev && !rxd_s) begin
            state_d   = StStart;
            tickcnt_d = '0;
          end
        end
        StStart: begin
          if (tickcnt_q == HalfLast) begin
            tickcnt_d = '0;
            bitcnt_d  = '0;
            state_d   = rxd_s ? StIdle : StData;
          end else begin
            tickcnt_d = tickcnt_q + TickW'(1);
          end
        end
        StData: begin
          if (tickcnt_q == BitLast) begin
            tickcnt_d         = '0;
            shift_d[bitcnt_q] = rxd_s;
            if (bitcnt_q == LastBit) begin
              bitcnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d  = StParity;
`else
              state_d  = StStop;
`endif
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end else begin
            tickcnt_d = tickcnt_q + TickW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tickcnt_q == BitLast) begin
            tickcnt_d = '0;
            par_bad_d = (^shift_q) ^ rxd_s;
            state_d   = StStop;
          end else begin
            tickcnt_d = tickcnt_q + TickW'(1);
          end
        end
`endif
        StStop: begin
          if (tickcnt_q == BitLast) begin
            tickcnt_d = '0;
            done_d    = 1'b1;
            stop_ok_d = rxd_s;
            state_d   = StIdle;
          end else begin
            tickcnt_d = tickcnt_q + TickW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign deliver = done_q & stop_ok_q;

  // Holding register and status pulses, one clk after the stop-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (deliver && (!valid_q || ready)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      overrun_q   <= deliver & valid_q & ~ready;
      frame_err_q <= done_q & ~stop_ok_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  // Parity result shares the frame_err timing; the byte is still delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= done_q & par_bad_q;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ps
// Bench for uart_rx: random and directed frames against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned OS      = 16;
  localparam int unsigned TickDiv = 4;
  localparam int unsigned BitClks = OS * TickDiv;
`ifdef UART_RX_PARITY_EN
  localparam bit ParityOn = 1'b1;
`else
  localparam bit ParityOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       rxd7 = 1'b1;
  logic       ready = 1'b1;
  logic       ready7 = 1'b1;
  logic [7:0] data, data7;
  logic       valid, frame_err, overrun, parity_err, busy;
  logic       valid7, frame_err7, overrun7, parity_err7, busy7;

  int checks = 0;
  int errors = 0;
  byte unsigned rx_q[$], exp_q[$], rx7_q[$], exp7_q[$];
  int valid_cycles = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, perr7_cnt = 0;
  int exp_ferr = 0, exp_ovr = 0, exp_perr = 0, exp_perr7 = 0;
  bit m_pending = 1'b0;  // model: a byte sits unconsumed in the holding register

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_tick(sample_tick), .rxd(rxd),
    .data(data), .valid(valid), .ready(ready), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err), .busy(busy)
  );

  uart_rx #(.DATA_BITS(7), .OVERSAMPLE(OS)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .sample_tick(sample_tick), .rxd(rxd7),
    .data(data7), .valid(valid7), .ready(ready7), .frame_err(frame_err7),
    .overrun(overrun7), .parity_err(parity_err7), .busy(busy7)
  );

  always #5 clk = ~clk;

  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      sample_tick = (cnt == 0);
      cnt = (cnt + 1) % TickDiv;
    end
  end

  // Observe consumed bytes and status pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) rx_q.push_back(data);
      if (valid7 && ready7) rx7_q.push_back(data7);
      if (valid) valid_cycles++;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (parity_err) perr_cnt++;
      if (parity_err7) perr7_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(bit sel7, logic v, int n);
    if (sel7) rxd7 = v;
    else rxd = v;
    wait_clks(n);
  endtask

  // Reference model: what a frame should do to the consumer-visible stream.
  task automatic model_frame(bit sel7, byte unsigned b, int nbits, logic stop_bit, bit pflip);
    byte unsigned m;
    m = b & 8'((1 << nbits) - 1);
    if (ParityOn && pflip) begin
      if (sel7) exp_perr7++;
      else exp_perr++;
    end
    if (!stop_bit) exp_ferr++;
    else if (sel7) exp7_q.push_back(m);
    else if (m_pending && !ready) exp_ovr++;
    else begin
      exp_q.push_back(m);
      m_pending = !ready;
    end
  endtask

  task automatic rx_frame(bit sel7, byte unsigned b, int nbits, logic stop_bit, bit pflip);
    bit par;
    model_frame(sel7, b, nbits, stop_bit, pflip);
    drive_bit(sel7, 1'b0, BitClks);
    par = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      drive_bit(sel7, b[i], BitClks);
      par ^= b[i];
    end
    if (ParityOn) drive_bit(sel7, par ^ pflip, BitClks);
    drive_bit(sel7, stop_bit, BitClks);
  endtask

  task automatic check_rx(string tag);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    byte unsigned b;
    // Reset values
    wait_clks(3);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_data7", 32'(data7), 32'h0);
    rst_n = 1'b1;
    wait_clks(10);

    // Basic receive, then random bytes with random idle gaps
    valid_cycles = 0;
    rx_frame(1'b0, 8'hA5, 8, 1'b1, 1'b0);
    wait_clks(BitClks);
    check("basic_valid_1clk", 32'(valid_cycles), 32'd1);
    check("basic_busy_idle", 32'(busy), 32'h0);
    check("basic_data", 32'(data), 32'hA5);
    check_rx("basic");
    valid_cycles = 0;
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      rx_frame(1'b0, b, 8, 1'b1, 1'b0);
      drive_bit(1'b0, 1'b1, $urandom_range(1, 40));
    end
    wait_clks(BitClks);
    check("rand_valid_cycles", 32'(valid_cycles), 32'd5);
    check_rx("rand");

    // False start
    rxd = 1'b0;
    wait_clks(5 * TickDiv);
    check("fs_busy_during", 32'(busy), 32'h1);
    rxd = 1'b1;
    wait_clks(30);
    check("fs_busy_after", 32'(busy), 32'h0);
    wait_clks(BitClks);
    check("fs_valid", 32'(valid), 32'h0);
    check_rx("false_start");

    // Framing error, then a 40-tick break that must not retrigger
    rx_frame(1'b0, 8'h3C, 8, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 40 * TickDiv);
    check("ferr_break_busy", 32'(busy), 32'h0);
    check("ferr_valid", 32'(valid), 32'h0);
    check("ferr_count", 32'(ferr_cnt), 32'(exp_ferr));
    drive_bit(1'b0, 1'b1, BitClks);
    rx_frame(1'b0, 8'h11, 8, 1'b1, 1'b0);
    wait_clks(BitClks);
    check("ferr_after_data", 32'(data), 32'h11);
    check_rx("frame_err");

    // Overrun
    ready = 1'b0;
    rx_frame(1'b0, 8'h12, 8, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1, 20);
    rx_frame(1'b0, 8'h34, 8, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1, 20);
    check("ovr_data", 32'(data), 32'h12);
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_count", 32'(ovr_cnt), 32'(exp_ovr));
    ready = 1'b1;
    m_pending = 1'b0;
    wait_clks(3);
    check("ovr_valid_drop", 32'(valid), 32'h0);
    check_rx("overrun");

    // Enable dropped during bit 3 of 0xFF
    drive_bit(1'b0, 1'b0, BitClks);
    drive_bit(1'b0, 1'b1, 3 * BitClks + BitClks / 2);
    check("en_busy_before", 32'(busy), 32'h1);
    enable = 1'b0;
    wait_clks(2);
    check("en_busy_cleared", 32'(busy), 32'h0);
    enable = 1'b1;
    wait_clks(12 * BitClks);
    check("en_busy_after", 32'(busy), 32'h0);
    check("en_valid", 32'(valid), 32'h0);
    rx_frame(1'b0, 8'h5A, 8, 1'b1, 1'b0);
    wait_clks(BitClks);
    check_rx("enable");

    // Asynchronous reset mid-frame with a byte held
    ready = 1'b0;
    rx_frame(1'b0, 8'h77, 8, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1, 20);
    check("arst_held_valid", 32'(valid), 32'h1);
    drive_bit(1'b0, 1'b0, 2 * BitClks);
    check("arst_busy_before", 32'(busy), 32'h1);
    #3;
    rst_n = 1'b0;
    rxd = 1'b1;
    #1;
    check("arst_data", 32'(data), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    if (m_pending) void'(exp_q.pop_back());
    m_pending = 1'b0;
    ready = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2 * BitClks);
    check_rx("arst");

    // Seven-bit instance, including a corrupted parity bit
    rx_frame(1'b1, 8'h7F, 7, 1'b1, 1'b0);
    wait_clks(BitClks);
    check("db7_data", 32'(data7), 32'h7F);
    check("db7_msb_zero", 32'(data7[7]), 32'h0);
    b = 8'($urandom);
    rx_frame(1'b1, b, 7, 1'b1, 1'b1);
    wait_clks(BitClks);
    check("db7_parity_cnt", 32'(perr7_cnt), 32'(exp_perr7));
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      rx_frame(1'b1, b, 7, 1'b1, 1'b0);
      drive_bit(1'b1, 1'b1, $urandom_range(1, 30));
    end
    wait_clks(BitClks);
    check("db7_count", 32'(rx7_q.size()), 32'(exp7_q.size()));
    for (int i = 0; i < exp7_q.size() && i < rx7_q.size(); i++)
      check("db7_byte", 32'(rx7_q[i]), 32'(exp7_q[i]));

    // Totals across the whole run
    check("total_frame_err", 32'(ferr_cnt), 32'(exp_ferr));
    check("total_overrun", 32'(ovr_cnt), 32'(exp_ovr));
    check("total_parity_err", 32'(perr_cnt), 32'(exp_perr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
